// File: rtl/sobel_frame_ctrl.sv
// Frame/line sequencer for the Sobel chain: pixel/line counting, prime gating and flush-line
// injection. Optional statistics outputs are enabled by defining SOBEL_FRAME_CTRL_STATS_EN.
module sobel_frame_ctrl #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned PRIME_LINES = 2,
  parameter int unsigned H_GAP       = 16,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dv_i,
  input  logic             vs_i,
  output logic             dv_o,
  output logic             line_end_o,
  output logic             frame_start_o,
  output logic             conv_en_o,
  output logic             border_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic [CNT_W-1:0] line_cnt_o,
  output logic [1:0]       state_o,
  output logic             err_o
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0]      frame_cnt_o,
  output logic [7:0]       drop_cnt_o
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPrime = 2'b01,
    StRun   = 2'b10,
    StFlush = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] HAct     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HLast    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VAct     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VLast    = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] PrimeCnt = CNT_W'(PRIME_LINES);
  localparam logic [CNT_W-1:0] FlushEnd = CNT_W'(V_ACTIVE + PRIME_LINES);
  localparam logic [CNT_W-1:0] GapCnt   = CNT_W'(H_GAP);
  localparam logic [CNT_W-1:0] PixMax   = '1;

  state_e           state_q, state_d;
  logic             vs_q;
  logic             vs_rise;
  logic             syn_on_q, syn_on_d;
  logic [CNT_W-1:0] syn_cnt_q, syn_cnt_d;
  logic             dv_d, le_d, conv_d, border_d, err_d;
  logic [CNT_W-1:0] pix_d, line_d, completed, row;

  always_comb begin
    vs_rise   = vs_i & ~vs_q;
    syn_on_d  = syn_on_q;
    syn_cnt_d = syn_cnt_q;
    dv_d      = 1'b0;
    case (state_q)
      StPrime, StRun: dv_d = dv_i;
      StFlush: begin
        // Synthetic line: H_GAP low cycles (line-end cycle included), then H_ACTIVE beats.
        if (syn_on_q) begin
          if (syn_cnt_q == HAct) begin
            syn_on_d  = 1'b0;
            syn_cnt_d = CNT_W'(1);
          end else begin
            dv_d      = 1'b1;
            syn_cnt_d = syn_cnt_q + 1'b1;
          end
        end else if (syn_cnt_q == GapCnt) begin
          dv_d      = 1'b1;
          syn_on_d  = 1'b1;
          syn_cnt_d = CNT_W'(1);
        end else begin
          syn_cnt_d = syn_cnt_q + 1'b1;
        end
        if (vs_rise) dv_d = 1'b0;
      end
      default: dv_d = 1'b0;
    endcase

    le_d      = dv_o & ~dv_d;
    completed = line_cnt_o + 1'b1;

    state_d = state_q;
    if (le_d) begin
      case (state_q)
        StPrime: if (completed == PrimeCnt) state_d = StRun;
        StRun:   if (completed == VAct) state_d = StFlush;
        StFlush: if (completed == FlushEnd) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
    if (state_q == StRun && state_d == StFlush) begin
      syn_on_d  = 1'b0;
      syn_cnt_d = CNT_W'(1);
    end
    if (vs_rise) state_d = StPrime;

    if (vs_rise || le_d) begin
      pix_d = '0;
    end else if (dv_d && dv_o) begin
      pix_d = (pix_cnt_o == PixMax) ? pix_cnt_o : pix_cnt_o + 1'b1;
    end else if (dv_d) begin
      pix_d = '0;
    end else begin
      pix_d = pix_cnt_o;
    end

    if (vs_rise)   line_d = '0;
    else if (le_d) line_d = completed;
    else           line_d = line_cnt_o;

    if (vs_rise) begin
      err_d = 1'b0;
    end else begin
      err_d = err_o | (le_d & (pix_cnt_o != HLast)) | ((state_q == StFlush) & dv_i);
    end

    conv_d   = dv_d & ~vs_rise & ((state_q == StRun) | (state_q == StFlush));
    row      = line_d - PrimeCnt;
    border_d = conv_d & ((pix_d == '0) | (pix_d == HLast) | (row == '0) | (row == VLast));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      vs_q          <= 1'b0;
      syn_on_q      <= 1'b0;
      syn_cnt_q     <= '0;
      dv_o          <= 1'b0;
      line_end_o    <= 1'b0;
      frame_start_o <= 1'b0;
      conv_en_o     <= 1'b0;
      border_o      <= 1'b0;
      pix_cnt_o     <= '0;
      line_cnt_o    <= '0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_i;
      syn_on_q      <= syn_on_d;
      syn_cnt_q     <= syn_cnt_d;
      dv_o          <= dv_d;
      line_end_o    <= le_d;
      frame_start_o <= vs_rise;
      conv_en_o     <= conv_d;
      border_o      <= border_d;
      pix_cnt_o     <= pix_d;
      line_cnt_o    <= line_d;
      err_o         <= err_d;
    end
  end

  assign state_o = state_q;

`ifdef SOBEL_FRAME_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (state_q == StFlush && state_d == StIdle) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (vs_rise && state_q != StIdle && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a small 8x4 frame: vector table for idle/start/latency,
// then hand-written sequences for full frames, short line, flush protocol error, abort and reset.
module tb_sobel_frame_ctrl;
  localparam int unsigned H = 8;
  localparam int unsigned V = 4;
  localparam int unsigned P = 2;
  localparam int unsigned G = 3;
  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         dv_i, vs_i;
  logic         dv_o, line_end_o, frame_start_o, conv_en_o, border_o, err_o;
  logic [W-1:0] pix_cnt_o, line_cnt_o;
  logic [1:0]   state_o;
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  logic [15:0]  frame_cnt_o;
  logic [7:0]   drop_cnt_o;
`endif

  sobel_frame_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PRIME_LINES(P), .H_GAP(G), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .dv_i(dv_i), .vs_i(vs_i),
    .dv_o(dv_o), .line_end_o(line_end_o), .frame_start_o(frame_start_o),
    .conv_en_o(conv_en_o), .border_o(border_o), .pix_cnt_o(pix_cnt_o),
    .line_cnt_o(line_cnt_o), .state_o(state_o), .err_o(err_o)
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    , .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_err  = 0;
  int le_cnt = 0;

  typedef struct {
    logic       dv;
    logic       vs;
    logic       e_dv;
    logic       e_le;
    logic       e_fs;
    logic [1:0] e_st;
    int         e_pix;
    int         e_line;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic dv, input logic vs);
    dv_i = dv;
    vs_i = vs;
    @(posedge clk);
    #1;
    if (line_end_o) le_cnt++;
  endtask

  task automatic add_vec(input logic dv, input logic vs, input logic e_dv, input logic e_le,
                         input logic e_fs, input logic [1:0] e_st, input int e_pix,
                         input int e_line);
    vec_t v;
    v.dv = dv; v.vs = vs; v.e_dv = e_dv; v.e_le = e_le; v.e_fs = e_fs;
    v.e_st = e_st; v.e_pix = e_pix; v.e_line = e_line;
    vecs.push_back(v);
  endtask

  // One beat already clocked: check it against the expected pixel/line/state.
  task automatic beat_chk(input int p, input int li, input logic [1:0] st);
    logic ce, bd;
    int   row;
    row = li - int'(P);
    ce  = (st == 2'b10) || (st == 2'b11);
    bd  = ce && (p == 0 || p == H - 1 || row == 0 || row == V - 1);
    chk("beat_dv", dv_o, 1);
    chk("beat_pix", pix_cnt_o, p);
    chk("beat_line", line_cnt_o, li);
    chk("beat_conv_en", conv_en_o, ce);
    chk("beat_border", border_o, bd);
    chk("beat_state", state_o, st);
  endtask

  task automatic end_chk(input int li, input logic [1:0] st_after, input logic e_err);
    chk("end_line_end", line_end_o, 1);
    chk("end_dv", dv_o, 0);
    chk("end_pix", pix_cnt_o, 0);
    chk("end_line", line_cnt_o, li + 1);
    chk("end_state", state_o, st_after);
    chk("end_err", err_o, e_err);
  endtask

  task automatic send_line(input int n, input int li, input logic [1:0] st,
                           input logic [1:0] st_after, input logic e_err);
    for (int p = 0; p < n; p++) begin
      tick(1'b1, 1'b0);
      beat_chk(p, li, st);
    end
    tick(1'b0, 1'b0);
    end_chk(li, st_after, e_err);
  endtask

  task automatic flush_gap(input logic inject);
    for (int g = 0; g < int'(G) - 1; g++) begin
      tick(inject, 1'b0);
      chk("gap_dv", dv_o, 0);
      chk("gap_state", state_o, 2'b11);
    end
  endtask

  task automatic flush_line(input int li, input logic [1:0] st_after, input logic inject,
                            input logic e_err);
    flush_gap(inject);
    for (int p = 0; p < int'(H); p++) begin
      tick(1'b0, 1'b0);
      beat_chk(p, li, 2'b11);
    end
    tick(1'b0, 1'b0);
    end_chk(li, st_after, e_err);
  endtask

  task automatic start_frame();
    tick(1'b0, 1'b1);
    chk("fs_pulse", frame_start_o, 1);
    chk("fs_state", state_o, 2'b01);
    chk("fs_line", line_cnt_o, 0);
    chk("fs_pix", pix_cnt_o, 0);
    chk("fs_err", err_o, 0);
    tick(1'b0, 1'b0);
    chk("fs_one_cycle", frame_start_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    dv_i = 1'b0;
    vs_i = 1'b0;
    #12;
    chk("rst_dv", dv_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle ignore, frame start, and first-line latency.
    add_vec(1, 0, 0, 0, 0, 2'b00, 0, 0);
    add_vec(0, 0, 0, 0, 0, 2'b00, 0, 0);
    add_vec(0, 1, 0, 0, 1, 2'b01, 0, 0);
    add_vec(0, 1, 0, 0, 0, 2'b01, 0, 0);
    for (int p = 0; p < int'(H); p++) add_vec(1, 0, 1, 0, 0, 2'b01, p, 0);
    add_vec(0, 0, 0, 1, 0, 2'b01, 0, 1);
    add_vec(0, 0, 0, 0, 0, 2'b01, 0, 1);

    le_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].dv, vecs[i].vs);
      chk($sformatf("vec%0d_dv", i), dv_o, vecs[i].e_dv);
      chk($sformatf("vec%0d_le", i), line_end_o, vecs[i].e_le);
      chk($sformatf("vec%0d_fs", i), frame_start_o, vecs[i].e_fs);
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].e_st);
      chk($sformatf("vec%0d_pix", i), pix_cnt_o, vecs[i].e_pix);
      chk($sformatf("vec%0d_line", i), line_cnt_o, vecs[i].e_line);
      chk($sformatf("vec%0d_conv", i), conv_en_o, 0);
    end

    // Frame 1: rest of a nominal frame plus two flush lines.
    send_line(8, 1, 2'b01, 2'b10, 0);
    send_line(8, 2, 2'b10, 2'b10, 0);
    send_line(8, 3, 2'b10, 2'b11, 0);
    flush_line(4, 2'b11, 0, 0);
    flush_line(5, 2'b00, 0, 0);
    chk("frame1_line_ends", le_cnt, 6);
    tick(1'b1, 1'b0);
    chk("idle_after_flush_dv", dv_o, 0);

    // Frame 2: short line in RUN.
    start_frame();
    send_line(8, 0, 2'b01, 2'b01, 0);
    send_line(8, 1, 2'b01, 2'b10, 0);
    send_line(6, 2, 2'b10, 2'b10, 1);
    send_line(8, 3, 2'b10, 2'b11, 1);
    flush_line(4, 2'b11, 0, 1);
    flush_line(5, 2'b00, 0, 1);

    // Frame 3: dv_i during flush gap, then abort during the second flush line.
    start_frame();
    send_line(8, 0, 2'b01, 2'b01, 0);
    send_line(8, 1, 2'b01, 2'b10, 0);
    send_line(8, 2, 2'b10, 2'b10, 0);
    send_line(8, 3, 2'b10, 2'b11, 0);
    chk("pre_inject_err", err_o, 0);
    flush_line(4, 2'b11, 1, 1);
    flush_gap(0);
    for (int p = 0; p < 3; p++) begin
      tick(1'b0, 1'b0);
      beat_chk(p, 5, 2'b11);
    end
    tick(1'b0, 1'b1);
    chk("abort_fs", frame_start_o, 1);
    chk("abort_le", line_end_o, 1);
    chk("abort_dv", dv_o, 0);
    chk("abort_state", state_o, 2'b01);
    chk("abort_line", line_cnt_o, 0);
    chk("abort_pix", pix_cnt_o, 0);
    chk("abort_err", err_o, 0);
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    chk("abort_drop_cnt", drop_cnt_o, 1);
    chk("abort_frame_cnt", frame_cnt_o, 2);
`endif
    tick(1'b0, 1'b0);

    // Frame 4: asynchronous reset in the middle of RUN.
    send_line(8, 0, 2'b01, 2'b01, 0);
    send_line(8, 1, 2'b01, 2'b10, 0);
    for (int p = 0; p < 3; p++) begin
      tick(1'b1, 1'b0);
      beat_chk(p, 2, 2'b10);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_dv", dv_o, 0);
    chk("async_rst_conv", conv_en_o, 0);
    chk("async_rst_border", border_o, 0);
    chk("async_rst_pix", pix_cnt_o, 0);
    chk("async_rst_line", line_cnt_o, 0);
    chk("async_rst_state", state_o, 0);
`ifdef SOBEL_FRAME_CTRL_STATS_EN
    chk("async_rst_drop", drop_cnt_o, 0);
`endif
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      chk("post_rst_dv_ignored", dv_o, 0);
      chk("post_rst_state", state_o, 0);
    end
    tick(1'b0, 1'b0);
    chk("post_rst_le", line_end_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
